psi_inv_table_gen: RTL

Sequential generator and read port for the inverse twiddle factors used by the INTT datapath (n = 32, q = 65537, psi = 2, psi^-1 = 32769). On `start` it computes psi^-k mod q for k = 0..31 by repeated multiplication by psi^-1, stores each value in a 32-entry register file, then serves registered single-cycle reads to the inverse butterfly scheduler. It is the inverse-direction counterpart of the forward psi table.

---
 rtl/psi_inv_table_gen_if.sv | 24 ++
 rtl/psi_inv_table_gen.sv | 91 +++++++++
 2 files changed

// File: rtl/psi_inv_table_gen_if.sv
// Handshake and read-port bundle for psi_inv_table_gen: generation control plus the registered table read port.
interface psi_inv_table_gen_if #(
  parameter int W    = 17,
  parameter int LOGN = 5
);
  logic            start;
  logic            busy;
  logic            done;
  logic            table_valid;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr;
  logic            rd_valid;
  logic [W-1:0]    rd_data;

  modport master (
    output start, rd_en, rd_addr,
    input  busy, done, table_valid, rd_valid, rd_data
  );

  modport slave (
    input  start, rd_en, rd_addr,
    output busy, done, table_valid, rd_valid, rd_data
  );
endinterface

// File: rtl/psi_inv_table_gen.sv
// Builds psi^-k mod 65537 (k=0..31) in 33 cycles; 1-cycle registered reads, accepted only while idle with a valid table.
// Optional PSI_INV_BITREV_EN stores entry k at bit-reverse5(k) instead of k.
module psi_inv_table_gen (
  input  logic               clk,
  input  logic               rst,
  psi_inv_table_gen_if.slave bus
);
  localparam int         W    = 17;
  localparam int         N    = 32;
  localparam int         LOGN = 5;
  localparam logic [W:0] Q    = 18'd65537;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      acc;
  logic [LOGN-1:0]   k;
  logic [W-1:0]      tbl [N];
  logic              busy_q, done_q, tv_q, rd_valid_q;
  logic [W-1:0]      rd_data_q;
  logic [W:0]        acc_sum;
  logic [W-1:0]      acc_half;
  logic              rd_acc;

  function automatic logic [LOGN-1:0] waddr(input logic [LOGN-1:0] kk);
    logic [LOGN-1:0] r;
    r = kk;
`ifdef PSI_INV_BITREV_EN
    for (int i = 0; i < LOGN; i++) r[i] = kk[LOGN-1-i];
`endif
    return r;
  endfunction

  // Halving mod Q: odd values borrow one Q so the shift is exact; sum needs 18 bits.
  always_comb begin
    acc_sum  = acc[0] ? ({1'b0, acc} + Q) : {1'b0, acc};
    acc_half = W'(acc_sum >> 1);
  end

  assign rd_acc = bus.rd_en && tv_q && (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = GEN;
      GEN:     if (k == LOGN'(N-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      k          <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tv_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < N; i++) tbl[i] <= '0;
    end else begin
      state      <= state_nxt;
      busy_q     <= (state == GEN);
      done_q     <= (state == DONE);
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= tbl[bus.rd_addr];
      case (state)
        IDLE: if (bus.start) begin
          acc  <= W'(1);
          k    <= '0;
          tv_q <= 1'b0;
        end
        GEN: begin
          tbl[waddr(k)] <= acc;
          acc           <= acc_half;
          k             <= k + 1'b1;
        end
        DONE:    tv_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.table_valid = tv_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
endmodule
